// File: rtl/i2s_rx_ctrl_module.sv
// I2S receive master controller: generates bck/lrck, captures one left/right pair per frame, valid/ready output.
// Define I2S_RX_CTRL_OVR_CNT_EN to add the saturating dropped-pair counter on ovr_cnt_o.
module i2s_rx_ctrl_module #(
    parameter int FRAME_RES = 32,
    parameter int DATA_RES  = 24,
    parameter int DIV_RES   = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [DIV_RES-1:0]  div_i,
    input  logic                clr_i,
    input  logic [DATA_RES-1:0] left_i,
    input  logic [DATA_RES-1:0] right_i,
    output logic                bck_o,
    output logic                lrck_o,
    output logic                busy_o,
    output logic [DATA_RES-1:0] left_o,
    output logic [DATA_RES-1:0] right_o,
    output logic                valid_o,
    input  logic                ready_i,
`ifdef I2S_RX_CTRL_OVR_CNT_EN
    output logic [15:0]         ovr_cnt_o,
`endif
    output logic                overrun_o
);

    localparam int BCNT_W = $clog2(2 * FRAME_RES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_RES-1:0]  div_q, dcnt;
    logic [BCNT_W-1:0]   bcnt, bcnt_inc;
    logic                first;
    logic                tick, cap_pt, capture, xfer, drop;

    assign busy_o   = (state_q != S_IDLE);
    assign tick     = busy_o && (dcnt == div_q);
    // Capture on the 3rd bck rising edge of the frame, once the receiver has settled.
    assign cap_pt   = tick && !bck_o && (bcnt == BCNT_W'(2));
    assign capture  = cap_pt && !first;
    assign xfer     = valid_o && ready_i;
    assign drop     = capture && valid_o && !ready_i;
    assign bcnt_inc = bcnt + 1'b1;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (en_i)   state_d = S_RUN;
            S_RUN:   if (!en_i)  state_d = S_STOP;
            S_STOP:  if (cap_pt) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q  <= '0;
            dcnt   <= '0;
            bcnt   <= '0;
            first  <= 1'b1;
            bck_o  <= 1'b0;
            lrck_o <= 1'b0;
        end else if (state_q == S_IDLE) begin
            bck_o  <= 1'b0;
            lrck_o <= 1'b0;
            if (en_i) begin
                div_q <= div_i;
                dcnt  <= '0;
                bcnt  <= '0;
                first <= 1'b1;
            end
        end else if (state_d == S_IDLE) begin
            // Leaving STOP: park the clocks low instead of issuing the bck rise.
            bck_o  <= 1'b0;
            lrck_o <= 1'b0;
            dcnt   <= '0;
        end else begin
            if (tick) begin
                dcnt  <= '0;
                bck_o <= ~bck_o;
                if (bck_o) begin
                    bcnt   <= bcnt_inc;
                    lrck_o <= bcnt_inc[BCNT_W-1];
                end
            end else begin
                dcnt <= dcnt + 1'b1;
            end
            if (cap_pt) first <= 1'b0;
        end
    end

    // Output register and handshake stay live in every state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            left_o    <= '0;
            right_o   <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (capture && (!valid_o || ready_i)) begin
                left_o  <= left_i;
                right_o <= right_i;
                valid_o <= 1'b1;
            end else if (xfer) begin
                valid_o <= 1'b0;
            end
            if (drop)       overrun_o <= 1'b1;
            else if (clr_i) overrun_o <= 1'b0;
        end
    end

`ifdef I2S_RX_CTRL_OVR_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovr_cnt_o <= '0;
        end else if (drop) begin
            if (ovr_cnt_o != 16'hFFFF) ovr_cnt_o <= ovr_cnt_o + 16'd1;
        end else if (clr_i) begin
            ovr_cnt_o <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx_ctrl_module.sv
// Scoreboard bench for i2s_rx_ctrl_module: stimulus pushes expected pairs, a negedge monitor pops on each transfer.
module tb_i2s_rx_ctrl_module;

    logic        clk_i = 1'b0;
    logic        rst_ni, en_i, clr_i, ready_i;
    logic [7:0]  div_i;
    logic [23:0] left_i, right_i, left_o, right_o;
    logic        bck_o, lrck_o, busy_o, valid_o, overrun_o;
`ifdef I2S_RX_CTRL_OVR_CNT_EN
    logic [15:0] ovr_cnt;
`endif

    always #5 clk_i = ~clk_i;

    i2s_rx_ctrl_module #(.FRAME_RES(32), .DATA_RES(24), .DIV_RES(8)) dut (
`ifdef I2S_RX_CTRL_OVR_CNT_EN
        .ovr_cnt_o (ovr_cnt),
`endif
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .div_i     (div_i),
        .clr_i     (clr_i),
        .left_i    (left_i),
        .right_i   (right_i),
        .bck_o     (bck_o),
        .lrck_o    (lrck_o),
        .busy_o    (busy_o),
        .left_o    (left_o),
        .right_o   (right_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .overrun_o (overrun_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          t_ref = 0;
    logic [47:0] sb[$];
    logic [47:0] exp_pair;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t_ref);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc - t_ref < k) step();
    endtask

    task automatic set_data(input logic [23:0] l, input logic [23:0] r, input bit push);
        left_i  = l;
        right_i = r;
        if (push) sb.push_back({l, r});
    endtask

    // Monitor: every transfer must match the oldest expected pair.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pair: got %h_%h expected none", left_o, right_o);
            end else begin
                exp_pair = sb.pop_front();
                check("pair", {16'h0, left_o, right_o}, {16'h0, exp_pair});
            end
        end
    end

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; div_i = 8'd1; clr_i = 1'b0; ready_i = 1'b1;
        left_i = 24'h111111; right_i = 24'h222222;
        repeat (3) step();
        check("reset_ctl", {bck_o, lrck_o, busy_o, valid_o, overrun_o}, 5'b0);
        check("reset_left", left_o, 24'h0);
        check("reset_right", right_o, 24'h0);
`ifdef I2S_RX_CTRL_OVR_CNT_EN
        check("reset_ovr_cnt", ovr_cnt, 16'h0);
`endif

        // Basic frame, div 1: bck period 4, frame 256 clk, capture at 10 + 256k.
        rst_ni = 1'b1;
        set_data(24'hA5A5A5, 24'h5A5A5A, 1'b1);
        sb.push_back({24'hA5A5A5, 24'h5A5A5A});
        en_i = 1'b1;
        step();
        t_ref = cyc;
        check("busy_rise", busy_o, 1'b1);
        run_to(2);   check("bck_rise1", bck_o, 1'b1);
        run_to(4);   check("bck_fall1", bck_o, 1'b0);
        run_to(6);   check("bck_rise2", bck_o, 1'b1);
        run_to(11);  check("first_frame_skipped", valid_o, 1'b0);
        run_to(127); check("lrck_left_end", lrck_o, 1'b0);
        run_to(128); check("lrck_right_start", lrck_o, 1'b1);
        run_to(255); check("lrck_right_end", lrck_o, 1'b1);
        run_to(256); check("lrck_wrap", lrck_o, 1'b0);
        run_to(265); check("valid_before", valid_o, 1'b0);
        run_to(266); check("valid_first", valid_o, 1'b1);
        run_to(267); check("valid_pulse", valid_o, 1'b0);
        run_to(530); set_data(24'h123456, 24'hABCDEF, 1'b1);

        // Overrun: captures at 1034 (held), 1290 and 1546 (dropped).
        run_to(780);  ready_i = 1'b0; set_data(24'hD1D1D1, 24'h1D1D1D, 1'b1);
        run_to(1100); set_data(24'hD2D2D2, 24'h2D2D2D, 1'b0);
        run_to(1550);
        check("ovr_set", overrun_o, 1'b1);
        check("ovr_valid_held", valid_o, 1'b1);
        check("ovr_left_held", left_o, 24'hD1D1D1);
        check("ovr_right_held", right_o, 24'h1D1D1D);
`ifdef I2S_RX_CTRL_OVR_CNT_EN
        check("ovr_cnt", ovr_cnt, 16'd2);
`endif
        clr_i = 1'b1;
        run_to(1551);
        clr_i = 1'b0;
        check("ovr_clr", overrun_o, 1'b0);
`ifdef I2S_RX_CTRL_OVR_CNT_EN
        check("ovr_cnt_clr", ovr_cnt, 16'd0);
`endif
        ready_i = 1'b1;
        set_data(24'hD3D3D3, 24'h3D3D3D, 1'b1);

        // Stop mid left slot: one more pair at 2058, then IDLE; en re-raised in STOP ignored.
        run_to(1850); en_i = 1'b0; set_data(24'hD4D4D4, 24'h4D4D4D, 1'b1);
        run_to(1900); en_i = 1'b1; div_i = 8'd0;
        run_to(2000); check("stop_busy", busy_o, 1'b1);
        run_to(2057); check("stop_busy_late", busy_o, 1'b1);
        run_to(2058);
        check("idle_busy", busy_o, 1'b0);
        check("idle_clocks", {bck_o, lrck_o}, 2'b00);
        check("stop_pair_valid", valid_o, 1'b1);
        run_to(2059); check("restart_busy", busy_o, 1'b1);

        // div 0: bck period 2, frame 128, capture at 5 + 128k; div_i change ignored.
        t_ref = cyc;
        run_to(1); check("div0_rise", bck_o, 1'b1);
        run_to(2); check("div0_fall", bck_o, 1'b0);
        run_to(3); check("div0_rise2", bck_o, 1'b1);
        run_to(4); div_i = 8'd255;
        run_to(5); check("div_change_rise", bck_o, 1'b1);
        run_to(6); check("div_change_fall", bck_o, 1'b0);
        run_to(10); set_data(24'hD5D5D5, 24'h5D5D5D, 1'b1);
        run_to(63); check("div0_lrck_left", lrck_o, 1'b0);
        run_to(64); check("div0_lrck_right", lrck_o, 1'b1);
        run_to(100); ready_i = 1'b0;
        run_to(132); check("div0_valid_before", valid_o, 1'b0);
        run_to(133); check("div0_valid", valid_o, 1'b1);
        run_to(140);
        check("pending_left", left_o, 24'hD5D5D5);
        rst_ni = 1'b0;
        run_to(141);
        check("midreset_ctl", {bck_o, lrck_o, busy_o, valid_o, overrun_o}, 5'b0);
        check("midreset_data", {left_o, right_o}, 48'h0);
        sb.delete();
        rst_ni = 1'b1; div_i = 8'd255;
        step();

        // div 255: bck period 512.
        t_ref = cyc;
        run_to(255); check("div255_low", bck_o, 1'b0);
        run_to(256); check("div255_rise", bck_o, 1'b1);
        run_to(511); check("div255_high", bck_o, 1'b1);
        run_to(512); check("div255_fall", bck_o, 1'b0);
        run_to(767); check("div255_low2", bck_o, 1'b0);
        run_to(768); check("div255_rise2", bck_o, 1'b1);
        run_to(770);
        rst_ni = 1'b0; en_i = 1'b0;
        step();

        // Clean restart after reset, div 0: first frame skipped, then stop.
        rst_ni = 1'b1; en_i = 1'b1; div_i = 8'd0; ready_i = 1'b1;
        set_data(24'hD6D6D6, 24'h6D6D6D, 1'b1);
        step();
        t_ref = cyc;
        run_to(5);   check("restart_cap_bck", bck_o, 1'b1);
        run_to(6);   check("restart_skip", valid_o, 1'b0);
        run_to(132); check("restart_valid_before", valid_o, 1'b0);
        run_to(133); check("restart_valid", valid_o, 1'b1);
        run_to(134); check("restart_pulse", valid_o, 1'b0);
        run_to(140);
        en_i = 1'b0;
        sb.push_back({24'hD6D6D6, 24'h6D6D6D});
        while (busy_o && (cyc - t_ref < 1000)) step();
        check("stop_latency", 64'(cyc - t_ref), 64'd261);
        check("stop_final_valid", valid_o, 1'b1);
        step();
        step();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
